// File: rtl/usbf_dma_sched_pkg.sv
// Shared types and widths for the USB function DMA channel scheduler.
package usbf_dma_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StXfer,
    StRelease
  } state_e;

  localparam int unsigned LenW  = 8;  // eng_len / word counter width
  localparam int unsigned HoldW = 4;  // per-channel holdoff counter width
  localparam int unsigned ChW   = 4;  // channel index width

endpackage

// File: rtl/usbf_dma_sched_if.sv
// Start/transfer handshake between the DMA scheduler (master) and the external DMA engine (slave).
interface usbf_dma_sched_if;
  import usbf_dma_sched_pkg::*;

  logic            start;
  logic [ChW-1:0]  ch;
  logic [LenW-1:0] len;
  logic            stop;
  logic            ready;
  logic            word;
  logic            done;

  modport master (output start, ch, len, stop, input ready, word, done);
  modport slave  (input start, ch, len, stop, output ready, word, done);
endinterface

// File: rtl/usbf_rr_pick.sv
// Combinational round-robin picker: first request not masked, searching upward from ptr with wrap.
module usbf_rr_pick
  import usbf_dma_sched_pkg::*;
#(
  parameter int unsigned N_CH = 16
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [N_CH-1:0] mask_i,
  input  logic [ChW-1:0]  ptr_i,
  output logic            valid_o,
  output logic [ChW-1:0]  idx_o
);

  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] shifted;
  int unsigned     c;

  always_comb begin
    elig    = req_i & ~mask_i;
    valid_o = 1'b0;
    idx_o   = '0;
    shifted = '0;
    c       = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      c = 32'(ptr_i) + i;
      if (c >= N_CH) c = c - N_CH;
      shifted = elig >> c;
      if (!valid_o && shifted[0]) begin
        valid_o = 1'b1;
        idx_o   = ChW'(c);
      end
    end
  end

endmodule

// File: rtl/usbf_dma_sched.sv
// Round-robin scheduler handing per-endpoint DMA requests to one shared DMA engine.
// Define USBF_DMA_SCHED_PRIO_EN to give channel 0 (control endpoint) strict priority.
module usbf_dma_sched
  import usbf_dma_sched_pkg::*;
#(
  parameter int unsigned N_CH    = 16,
  parameter int unsigned BURST   = 4,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  dma_req_i,
  output logic [N_CH-1:0]  dma_ack_o,
  usbf_dma_sched_if.master eng,
  output logic             busy_o,
  output logic             err_o
);

  state_e            state_q, state_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [ChW-1:0]    ptr_q, ptr_d;
  logic [LenW-1:0]   wcnt_q, wcnt_d;
  logic              stopped_q, stopped_d;
  logic              stop_q, stop_d;
  logic              err_q, err_d;
  logic [N_CH-1:0]   ack_q, ack_d;
  logic [HoldW-1:0]  hold_q [N_CH];
  logic [HoldW-1:0]  hold_d [N_CH];
  logic [N_CH-1:0]   mask;
  logic              rr_valid;
  logic [ChW-1:0]    rr_idx;
  logic [ChW-1:0]    pick_idx;
  logic [ChW-1:0]    next_ptr;

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) mask[i] = (hold_q[i] != '0);
  end

  usbf_rr_pick #(
    .N_CH (N_CH)
  ) u_pick (
    .req_i   (dma_req_i),
    .mask_i  (mask),
    .ptr_i   (ptr_q),
    .valid_o (rr_valid),
    .idx_o   (rr_idx)
  );

`ifdef USBF_DMA_SCHED_PRIO_EN
  // An eligible channel 0 also makes rr_valid true, so only the index needs overriding.
  assign pick_idx = (dma_req_i[0] && !mask[0]) ? '0 : rr_idx;
`else
  assign pick_idx = rr_idx;
`endif

  assign next_ptr = (ch_q == ChW'(N_CH - 1)) ? '0 : ch_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    ptr_d     = ptr_q;
    wcnt_d    = wcnt_q;
    stopped_d = stopped_q;
    stop_d    = 1'b0;
    ack_d     = '0;
    err_d     = err_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      hold_d[i] = (hold_q[i] != '0) ? hold_q[i] - 1'b1 : hold_q[i];
    end

    // Engine activity outside a transfer is a protocol error and otherwise ignored.
    if (state_q != StXfer && (eng.word || eng.done)) err_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (rr_valid) begin
          ch_d    = pick_idx;
          state_d = StStart;
        end
      end
      StStart: begin
        if (eng.ready) begin
          wcnt_d    = '0;
          stopped_d = 1'b0;
          state_d   = StXfer;
        end
      end
      StXfer: begin
        if (!dma_req_i[ch_q] && wcnt_q < LenW'(BURST) && !stopped_q) begin
          stop_d    = 1'b1;
          stopped_d = 1'b1;
        end
        if (eng.word) begin
          if (wcnt_q == LenW'(BURST)) begin
            err_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
            ack_d  = N_CH'(1) << ch_q;
          end
        end
        if (eng.done) state_d = StRelease;
      end
      StRelease: begin
        hold_d[ch_q] = HoldW'(HOLDOFF);
`ifdef USBF_DMA_SCHED_PRIO_EN
        if (ch_q != '0) ptr_d = next_ptr;
`else
        ptr_d = next_ptr;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      ptr_q     <= '0;
      wcnt_q    <= '0;
      stopped_q <= 1'b0;
      stop_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= '0;
      for (int unsigned i = 0; i < N_CH; i++) hold_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      ptr_q     <= ptr_d;
      wcnt_q    <= wcnt_d;
      stopped_q <= stopped_d;
      stop_q    <= stop_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      for (int unsigned i = 0; i < N_CH; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign eng.start = (state_q == StStart);
  assign eng.ch    = ch_q;
  assign eng.len   = LenW'(BURST);
  assign eng.stop  = stop_q;
  assign dma_ack_o = ack_q;
  assign busy_o    = (state_q != StIdle);
  assign err_o     = err_q;

endmodule
